// File: rtl/fifo_spi_tx.sv
// fifo_spi_tx: prefetches one word from the SRAM FIFO into a holding buffer
// and serves it to the MCU over a SPI slave link (mode 0, MSB first). The
// buffer is released only when a complete DATA_W-bit frame has been clocked.
//
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   fifo_empty          FIFO holds no words
//   fifo_busy           FIFO busy; no read request is issued while high
//   fifo_data_out       FIFO read data, valid with fifo_data_r_rdy
//   fifo_data_r_rdy     one-cycle strobe qualifying fifo_data_out
//   fifo_re             one-cycle read request to the FIFO
//   spi_sclk/cs_n/mosi  asynchronous SPI inputs from the MCU (mosi unused)
//   spi_miso            serial data to the MCU
//   data_avail          holding buffer valid (MCU interrupt line)
//   underrun            sticky: a frame started with an empty buffer
//   rd_err              sticky: FIFO read timed out
//   words_sent          count of completed frames, wraps to 0
module fifo_spi_tx #(
   parameter int DATA_W      = 32,
   parameter int SYNC_STAGES = 2,
   parameter int RD_TIMEOUT  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fifo_empty,
   input  logic              fifo_busy,
   input  logic [DATA_W-1:0] fifo_data_out,
   input  logic              fifo_data_r_rdy,
   output logic              fifo_re,
   input  logic              spi_sclk,
   input  logic              spi_cs_n,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              data_avail,
   output logic              underrun,
   output logic              rd_err,
   output logic [15:0]       words_sent
);

   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam int TMO_W = $clog2(RD_TIMEOUT + 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0] FULL_CNT = BIT_W'(DATA_W);
   // The counter starts at 0 in the first wait cycle, so hitting this value
   // means RD_TIMEOUT cycles have elapsed since the read pulse at the
   // moment rd_err becomes visible.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT - 2);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FULL} fetch_state_t;

   fetch_state_t state, next_state;

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic                   sclk_q, cs_q;
   logic                   sclk_s, cs_s;
   logic                   sclk_rise, sclk_fall, cs_fall, cs_rise, in_frame;
   logic                   unused_mosi;

   logic [DATA_W-1:0] buffer;
   logic [DATA_W-1:0] shift_reg;
   logic [BIT_W-1:0]  bit_cnt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              frame_ok;
   logic              consume;
   logic              tmo_hit;

   // ------------------------------------------------------------------
   // Input synchronisers and edge detection
   // ------------------------------------------------------------------
   // NOTE: every clocked register uses non-blocking assignment so all flops
   // sample the same pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_q    <= 1'b0;
         cs_q      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         sclk_q    <= sclk_s;
         cs_q      <= cs_s;
      end
   end

   assign sclk_s      = sclk_sync[SYNC_STAGES-1];
   assign cs_s        = cs_sync[SYNC_STAGES-1];
   assign unused_mosi = mosi_sync[SYNC_STAGES-1];

   assign sclk_rise = sclk_s & ~sclk_q;
   assign sclk_fall = ~sclk_s & sclk_q;
   assign cs_fall   = ~cs_s & cs_q;
   assign cs_rise   = cs_s & ~cs_q;
   // Frame membership uses the delayed cs so an sclk edge arriving together
   // with cs rising still belongs to the frame that is closing.
   assign in_frame  = ~cs_q;

   assign consume = sclk_rise & in_frame & frame_ok & (bit_cnt == LAST_BIT);

   // ------------------------------------------------------------------
   // Fetch FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   assign tmo_hit = (state == S_WAIT) && !fifo_data_r_rdy && (tmo_cnt == TMO_LAST);

   // NOTE: next_state is defaulted before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      unique case (state)
         // data_avail is always low in S_IDLE, so only FIFO status gates a fetch.
         S_IDLE: if (!fifo_empty && !fifo_busy) next_state = S_REQ;
         S_REQ:  next_state = S_WAIT;
         S_WAIT: begin
            if (fifo_data_r_rdy) next_state = S_FULL;
            else if (tmo_hit)    next_state = S_IDLE;
         end
         S_FULL: if (consume) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      fifo_re    = (state == S_REQ);
      data_avail = (state == S_FULL);
   end

   // NOTE: the holding buffer is reset as well, so a word fetched before a
   // reset can never be served after it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
         buffer  <= '0;
         rd_err  <= 1'b0;
      end else begin
         if (state == S_REQ)       tmo_cnt <= '0;
         else if (state == S_WAIT) tmo_cnt <= tmo_cnt + TMO_W'(1);
         if ((state == S_WAIT) && fifo_data_r_rdy) buffer <= fifo_data_out;
         if (tmo_hit) rd_err <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // SPI shift path
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift_reg  <= '0;
         bit_cnt    <= '0;
         frame_ok   <= 1'b0;
         underrun   <= 1'b0;
         words_sent <= '0;
      end else begin
         if (cs_fall) begin
            // Loading copies the buffer; the buffer itself is left intact so
            // an aborted frame can resend the same word.
            shift_reg <= data_avail ? buffer : '0;
            frame_ok  <= data_avail;
            bit_cnt   <= '0;
            if (!data_avail) underrun <= 1'b1;
         end else if (cs_rise) begin
            bit_cnt <= '0;
         end else if (in_frame) begin
            if (sclk_rise && (bit_cnt != FULL_CNT)) bit_cnt <= bit_cnt + BIT_W'(1);
            if (sclk_fall) shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
         end
         if (consume) words_sent <= words_sent + 16'd1;
      end
   end

   // Both current and delayed cs must be low: this hides the stale register
   // contents during the single cycle before the load takes effect.
   assign spi_miso = ~cs_s & ~cs_q & shift_reg[DATA_W-1];

endmodule

// File: tb/tb_fifo_spi_tx.sv
// Testbench for fifo_spi_tx: FIFO responder, SPI master, scoreboard monitor.
module tb_fifo_spi_tx;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          fifo_empty = 1'b1;
   logic          fifo_busy = 1'b0;
   logic [DW-1:0] fifo_data_out = '0;
   logic          fifo_data_r_rdy = 1'b0;
   logic          fifo_re;
   logic          spi_sclk = 1'b0;
   logic          spi_cs_n = 1'b1;
   logic          spi_mosi = 1'b0;
   logic          spi_miso;
   logic          data_avail;
   logic          underrun;
   logic          rd_err;
   logic [15:0]   words_sent;

   always #5 clk = ~clk;

   fifo_spi_tx #(.DATA_W(DW), .SYNC_STAGES(2), .RD_TIMEOUT(64)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .fifo_empty      (fifo_empty),
      .fifo_busy       (fifo_busy),
      .fifo_data_out   (fifo_data_out),
      .fifo_data_r_rdy (fifo_data_r_rdy),
      .fifo_re         (fifo_re),
      .spi_sclk        (spi_sclk),
      .spi_cs_n        (spi_cs_n),
      .spi_mosi        (spi_mosi),
      .spi_miso        (spi_miso),
      .data_avail      (data_avail),
      .underrun        (underrun),
      .rd_err          (rd_err),
      .words_sent      (words_sent)
   );

   typedef struct {
      int            nbits;
      logic [DW-1:0] bits;
   } frame_t;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: FIFO contents, words still owed to the MCU, counters.
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_words[$];
   frame_t        sb[$];
   int            exp_sent = 0;
   logic          exp_underrun = 1'b0;

   int            lat_fixed = 4;
   bit            no_rdy = 1'b0;
   int            pend_cnt = 0;
   logic [DW-1:0] pend_word = '0;

   int cyc = 0;
   int re_cnt = 0;
   int last_re = 0;
   int err_delay = -1;
   bit err_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // FIFO responder: pops on fifo_re and returns the word after a latency.
   initial begin : responder
      forever begin
         @(negedge clk);
         fifo_data_r_rdy = 1'b0;
         fifo_data_out   = $urandom;
         if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               fifo_data_out   = pend_word;
               fifo_data_r_rdy = 1'b1;
            end
         end
         if (fifo_re === 1'b1 && !no_rdy && fifo_q.size() > 0) begin
            pend_word = fifo_q.pop_front();
            pend_cnt  = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 8));
         end
         fifo_empty = (fifo_q.size() == 0);
      end
   end

   // Read-pulse counter, pulse-width check and timeout latency capture.
   initial begin : re_watch
      bit prev_re;
      bit prev_err;
      prev_re  = 1'b0;
      prev_err = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (fifo_re === 1'b1) begin
            re_cnt++;
            last_re = cyc;
            check("re_single_cycle", {31'd0, prev_re}, 32'd0);
         end
         if (rd_err === 1'b1 && !prev_err) begin
            err_delay = cyc - last_re;
            err_seen  = 1'b1;
         end
         prev_re  = (fifo_re === 1'b1);
         prev_err = (rd_err === 1'b1);
      end
   end

   // Scoreboard monitor: collects miso at each sclk rise, compares at cs rise.
   logic [DW-1:0] rx = '0;
   int            nb = 0;
   initial begin : monitor
      logic   ps, pc;
      frame_t f;
      ps = 1'b0;
      pc = 1'b1;
      forever begin
         @(spi_sclk or spi_cs_n);
         if (pc && !spi_cs_n) begin
            rx = '0;
            nb = 0;
         end else if (!pc && spi_cs_n) begin
            if (nb > 0) begin
               if (sb.size() == 0) begin
                  check("frame_unexpected", nb, 0);
               end else begin
                  f = sb.pop_front();
                  check("frame_bits", nb, f.nbits);
                  check("frame_data", rx, f.bits);
               end
            end
            nb = 0;
         end else if (!ps && spi_sclk && !spi_cs_n) begin
            rx = {rx[DW-2:0], spi_miso};
            nb++;
         end
         ps = spi_sclk;
         pc = spi_cs_n;
      end
   end

   // SPI master at clk/8; inputs change 1 time unit after a rising clk.
   task automatic spi_xfer(input int nbits, input bit raise);
      @(posedge clk); #1;
      spi_cs_n = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      for (int i = 0; i < nbits; i++) begin
         spi_sclk = 1'b1;
         repeat (4) @(posedge clk);
         #1;
         spi_sclk = 1'b0;
         repeat (4) @(posedge clk);
         #1;
      end
      if (raise) begin
         spi_cs_n = 1'b1;
         repeat (8) @(posedge clk);
      end
      @(negedge clk);
   endtask

   task automatic wait_avail(input int budget);
      int k;
      k = 0;
      while (data_avail !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("avail_wait", {31'd0, data_avail}, 32'd1);
   endtask

   task automatic wait_re(input int base, input int budget, input string name);
      int k;
      k = 0;
      while (re_cnt == base && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, re_cnt - base, 1);
   endtask

   // A frame as the model sees it: owed word (or zeros on underrun).
   task automatic do_frame(input int n);
      logic [DW-1:0] e;
      bit            had;
      had = (exp_words.size() > 0);
      if (had) begin
         wait_avail(200);
         e = exp_words[0] >> (DW - n);
         if (n == DW) begin
            exp_words.delete(0);
            exp_sent++;
         end
      end else begin
         e = '0;
         exp_underrun = 1'b1;
      end
      sb.push_back('{nbits: n, bits: e});
      spi_xfer(n, 1'b1);
      check("words_sent", {16'd0, words_sent}, exp_sent & 32'hFFFF);
      check("underrun", {31'd0, underrun}, {31'd0, exp_underrun});
      if (had && n < DW) check("avail_after_abort", {31'd0, data_avail}, 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_fifo_re", {31'd0, fifo_re}, 32'd0);
      check("rst_miso", {31'd0, spi_miso}, 32'd0);
      check("rst_avail", {31'd0, data_avail}, 32'd0);
      check("rst_underrun", {31'd0, underrun}, 32'd0);
      check("rst_rd_err", {31'd0, rd_err}, 32'd0);
      check("rst_words_sent", {16'd0, words_sent}, 32'd0);
      spi_sclk = 1'b0;
      spi_cs_n = 1'b1;
      fifo_q.delete();
      exp_words.delete();
      exp_sent     = 0;
      exp_underrun = 1'b0;
      no_rdy       = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin : main
      int            base;
      int            k;
      bit            seen;
      logic [DW-1:0] w;

      // Reset with a word waiting, then the first fetch and frame.
      fifo_q.push_back(32'hA5A5_0F0F);
      repeat (3) @(negedge clk);
      check("re_in_reset", re_cnt, 0);
      check("rst0_miso", {31'd0, spi_miso}, 32'd0);
      check("rst0_avail", {31'd0, data_avail}, 32'd0);
      check("rst0_flags", {30'd0, underrun, rd_err}, 32'd0);
      check("rst0_words_sent", {16'd0, words_sent}, 32'd0);
      exp_words.push_back(32'hA5A5_0F0F);
      base  = re_cnt;
      rst_n = 1'b1;
      wait_re(base, 3, "re_after_reset");
      wait_avail(20);
      do_frame(DW);
      check("avail_after_frame", {31'd0, data_avail}, 32'd0);

      // Back-to-back words.
      base = re_cnt;
      for (int i = 5; i <= 7; i++) begin
         fifo_q.push_back(DW'(i));
         exp_words.push_back(DW'(i));
      end
      for (int i = 0; i < 3; i++) do_frame(DW);
      repeat (20) @(negedge clk);
      check("b2b_re_count", re_cnt - base, 3);

      // Aborted frame, then the same word in full.
      fifo_q.push_back(32'h1234_5678);
      exp_words.push_back(32'h1234_5678);
      do_frame(12);
      do_frame(DW);

      // Underrun.
      do_frame(DW);

      // Read timeout.
      no_rdy = 1'b1;
      fifo_q.push_back(32'hDEAD_BEEF);
      k = 0;
      while (!err_seen && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("rd_err", {31'd0, rd_err}, 32'd1);
      check("rd_err_delay", err_delay, 64);
      do_reset();

      // Busy gating.
      fifo_busy = 1'b1;
      w = $urandom;
      fifo_q.push_back(w);
      exp_words.push_back(w);
      base = re_cnt;
      repeat (20) @(negedge clk);
      check("busy_no_re", re_cnt - base, 0);
      fifo_busy = 1'b0;
      wait_re(base, 5, "re_after_busy");
      wait_avail(20);

      // Reset at bit 10 of a frame.
      sb.push_back('{nbits: 10, bits: w >> (DW - 10)});
      spi_xfer(10, 1'b0);
      do_reset();

      // Reset mid-fetch with a late data_r_rdy.
      lat_fixed = 30;
      fifo_q.push_back(32'hCAFE_F00D);
      base = re_cnt;
      wait_re(base, 10, "re_before_fetch_reset");
      repeat (5) @(negedge clk);
      do_reset();
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (data_avail === 1'b1) seen = 1'b1;
      end
      check("late_rdy_ignored", {31'd0, seen}, 32'd0);
      lat_fixed = 0;

      // Randomized traffic against the model.
      for (int it = 0; it < 16; it++) begin
         if (it == 0 || $urandom_range(0, 2) == 0) begin
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
               w = $urandom;
               fifo_q.push_back(w);
               exp_words.push_back(w);
            end
         end else begin
            do_frame(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 31)) : DW);
         end
      end

      repeat (20) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      n_err++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog expired");
   end

endmodule
